// File: rtl/load_extend_unit_if.sv
// rtl/load_extend_unit_if.sv - load request / extended result handshake bundle
interface load_extend_unit_if #(
  parameter int DATA_W = 32,
  parameter int OFS_W  = $clog2(DATA_W / 8)
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [OFS_W-1:0]  in_addr_lo;
  logic [1:0]        in_size;
  logic              in_sign;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_fault;

  modport master (
    output in_valid, in_data, in_addr_lo, in_size, in_sign, out_ready,
    input  in_ready, out_valid, out_data, out_fault
  );

  modport slave (
    input  in_valid, in_data, in_addr_lo, in_size, in_sign, out_ready,
    output in_ready, out_valid, out_data, out_fault
  );
endinterface

// File: rtl/load_extend_unit.sv
// rtl/load_extend_unit.sv - load lane select, zero/sign extension and fault flagging
// Result is formed combinationally at the input and parked in an output + skid register pair.
module load_extend_unit #(
  parameter int DATA_W     = 32,
  parameter int BIG_ENDIAN = 0,
  parameter int OFS_W      = $clog2(DATA_W / 8)
) (
  input logic               clk,
  input logic               rstn,
  load_extend_unit_if.slave bus
);
  localparam int NB = DATA_W / 8;

  logic [OFS_W:0]    nbytes;
  logic [OFS_W:0]    lane;
  logic [OFS_W+3:0]  nbits;
  logic [OFS_W+2:0]  top;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] keep;
  logic [DATA_W-1:0] extended;
  logic              msb;
  logic              res_fault;
  logic [DATA_W-1:0] res_data;

  logic              or_valid, sk_valid;
  logic              or_fault, sk_fault;
  logic [DATA_W-1:0] or_data, sk_data;
  logic              accept, fire;

  // A dword on a 32-bit datapath truncates nbytes to 0; it is always a fault so the data is discarded.
  always_comb begin
    case (bus.in_size)
      2'd0:    nbytes = (OFS_W + 1)'(1);
      2'd1:    nbytes = (OFS_W + 1)'(2);
      2'd2:    nbytes = (OFS_W + 1)'(4);
      default: nbytes = (OFS_W + 1)'(8);
    endcase
  end

  always_comb begin
    if (BIG_ENDIAN != 0)
      lane = (OFS_W + 1)'(NB) - {1'b0, bus.in_addr_lo} - nbytes;
    else
      lane = {1'b0, bus.in_addr_lo};
  end

  always_comb begin
    nbits    = {nbytes, 3'b000};
    top      = nbits[OFS_W+2:0] - (OFS_W + 3)'(1);
    shifted  = bus.in_data >> {lane, 3'b000};
    keep     = ~({DATA_W{1'b1}} << nbits);
    msb      = shifted[top];
    extended = (shifted & keep) | ({DATA_W{bus.in_sign & msb}} & ~keep);
  end

  always_comb begin
    case (bus.in_size)
      2'd0:    res_fault = 1'b0;
      2'd1:    res_fault = bus.in_addr_lo[0];
      2'd2:    res_fault = |bus.in_addr_lo[1:0];
      default: res_fault = (DATA_W == 32) || (|bus.in_addr_lo);
    endcase
    res_data = res_fault ? '0 : extended;
  end

  assign accept = bus.in_valid && !sk_valid;
  assign fire   = or_valid && bus.out_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      or_valid <= 1'b0;
      or_data  <= '0;
      or_fault <= 1'b0;
      sk_valid <= 1'b0;
      sk_data  <= '0;
      sk_fault <= 1'b0;
    end else if (!or_valid || fire) begin
      if (sk_valid) begin
        or_valid <= 1'b1;
        or_data  <= sk_data;
        or_fault <= sk_fault;
        sk_valid <= accept;
        if (accept) begin
          sk_data  <= res_data;
          sk_fault <= res_fault;
        end
      end else begin
        or_valid <= accept;
        if (accept) begin
          or_data  <= res_data;
          or_fault <= res_fault;
        end
      end
    end else if (accept) begin
      sk_valid <= 1'b1;
      sk_data  <= res_data;
      sk_fault <= res_fault;
    end
  end

  // Ready depends only on skid occupancy, so out_ready never reaches in_ready combinationally.
  assign bus.in_ready  = !sk_valid;
  assign bus.out_valid = or_valid;
  assign bus.out_data  = or_data;
  assign bus.out_fault = or_fault;
endmodule

// File: tb/tb_load_extend_unit.sv
// tb/tb_load_extend_unit.sv - scoreboard bench for load_extend_unit (32 LE, 32 BE, 64 LE)
module tb_load_extend_unit;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  load_extend_unit_if #(.DATA_W(32), .OFS_W(2)) b0 ();
  load_extend_unit_if #(.DATA_W(32), .OFS_W(2)) b1 ();
  load_extend_unit_if #(.DATA_W(64), .OFS_W(3)) b2 ();

  load_extend_unit #(.DATA_W(32), .BIG_ENDIAN(0)) dut_le (.clk(clk), .rstn(rstn), .bus(b0));
  load_extend_unit #(.DATA_W(32), .BIG_ENDIAN(1)) dut_be (.clk(clk), .rstn(rstn), .bus(b1));
  load_extend_unit #(.DATA_W(64), .BIG_ENDIAN(0)) dut_64 (.clk(clk), .rstn(rstn), .bus(b2));

  int tests = 0;
  int failed = 0;
  logic [64:0] q0[$];
  logic [64:0] q1[$];
  logic [64:0] q2[$];
  bit stim_done;
  bit held_v = 1'b0;
  logic [64:0] held_val;

  typedef struct {
    int d; logic [63:0] w; int ofs; int sz; bit sg; logic [64:0] e;
  } vec_t;
  vec_t dir[$];

  task automatic cmp(input string nm, input logic [64:0] act, input logic [64:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Memory bytes are gathered by offset; the byte at the lowest offset is the field's LSB
  // (little-endian) or MSB (big-endian).
  function automatic logic [64:0] model(input int dw, input bit be, input logic [63:0] w,
                                        input int ofs, input int sz, input bit sg);
    int nb;
    int b;
    int pos;
    logic [7:0] by;
    logic [127:0] val;
    nb = dw / 8;
    b = 1 << sz;
    val = '0;
    if ((ofs % b) != 0 || b * 8 > dw) return {1'b1, 64'd0};
    for (int i = 0; i < b; i++) begin
      pos = be ? 8 * (nb - 1 - (ofs + i)) : 8 * (ofs + i);
      by = w[pos +: 8];
      if (be) val = val | (128'(by) << (8 * (b - 1 - i)));
      else    val = val | (128'(by) << (8 * i));
    end
    if (sg && val[8 * b - 1]) val = val | ~((128'd1 << (8 * b)) - 128'd1);
    if (dw == 32) val[63:32] = '0;
    return {1'b0, val[63:0]};
  endfunction

  task automatic drive(input int d, input bit v, input logic [63:0] w, input int ofs,
                       input int sz, input bit sg);
    case (d)
      0: begin
        b0.in_valid = v; b0.in_data = w[31:0]; b0.in_addr_lo = ofs[1:0];
        b0.in_size = sz[1:0]; b0.in_sign = sg;
      end
      1: begin
        b1.in_valid = v; b1.in_data = w[31:0]; b1.in_addr_lo = ofs[1:0];
        b1.in_size = sz[1:0]; b1.in_sign = sg;
      end
      default: begin
        b2.in_valid = v; b2.in_data = w; b2.in_addr_lo = ofs[2:0];
        b2.in_size = sz[1:0]; b2.in_sign = sg;
      end
    endcase
  endtask

  task automatic set_ordy(input int d, input bit r);
    case (d)
      0: b0.out_ready = r;
      1: b1.out_ready = r;
      default: b2.out_ready = r;
    endcase
  endtask

  function automatic bit rdy(input int d);
    case (d)
      0: return b0.in_ready;
      1: return b1.in_ready;
      default: return b2.in_ready;
    endcase
  endfunction

  function automatic bit ovalid(input int d);
    case (d)
      0: return b0.out_valid;
      1: return b1.out_valid;
      default: return b2.out_valid;
    endcase
  endfunction

  function automatic int qsize(input int d);
    case (d)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic push(input int d, input logic [64:0] e);
    case (d)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic put(input int d, input logic [63:0] w, input int ofs, input int sz,
                     input bit sg, input logic [64:0] e);
    bit ok;
    ok = 1'b0;
    drive(d, 1'b1, w, ofs, sz, sg);
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      if (rdy(d)) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (ok) begin
      push(d, e);
      @(posedge clk); #1;
    end else begin
      tests++; failed++;
      $display("FAIL accept_timeout: dut %0d in_ready stuck at 0, required 1", d);
    end
    drive(d, 1'b0, 64'd0, 0, 0, 1'b0);
  endtask

  task automatic drain(input int d);
    for (int t = 0; t < 200 && qsize(d) != 0; t++) @(posedge clk);
    #1;
    cmp($sformatf("drain_%0d", d), 65'(qsize(d)), 65'd0);
  endtask

  task automatic rand_run(input int d, input int n);
    int nb;
    int sz;
    int ofs;
    bit sg;
    logic [63:0] w;
    nb = (d == 2) ? 8 : 4;
    for (int i = 0; i < n; i++) begin
      w = {$urandom, $urandom};
      sz = $urandom_range(0, 3);
      ofs = $urandom_range(0, nb - 1);
      if ($urandom_range(0, 3) != 0) ofs = ofs - (ofs % (1 << sz));
      sg = 1'($urandom_range(0, 1));
      put(d, w, ofs, sz, sg, model(nb * 8, d == 1, w, ofs, sz, sg));
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
  endtask

  always @(negedge clk) begin
    if (rstn && b0.out_valid) begin
      if (held_v) cmp("le_hold_stable", {b0.out_fault, 32'd0, b0.out_data}, held_val);
      held_v = !b0.out_ready;
      held_val = {b0.out_fault, 32'd0, b0.out_data};
    end else begin
      held_v = 1'b0;
    end
    if (rstn && b0.out_valid && b0.out_ready) begin
      if (q0.size() == 0) begin
        tests++; failed++;
        $display("FAIL le_extra: got output %h, required none", b0.out_data);
      end else cmp("le_out", {b0.out_fault, 32'd0, b0.out_data}, q0.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rstn && b1.out_valid && b1.out_ready) begin
      if (q1.size() == 0) begin
        tests++; failed++;
        $display("FAIL be_extra: got output %h, required none", b1.out_data);
      end else cmp("be_out", {b1.out_fault, 32'd0, b1.out_data}, q1.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rstn && b2.out_valid && b2.out_ready) begin
      if (q2.size() == 0) begin
        tests++; failed++;
        $display("FAIL w64_extra: got output %h, required none", b2.out_data);
      end else cmp("w64_out", {b2.out_fault, b2.out_data}, q2.pop_front());
    end
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      drive(d, 1'b0, 64'd0, 0, 0, 1'b0);
      set_ordy(d, 1'b0);
    end
    #1;
    cmp("rst_out_valid", 65'(b0.out_valid), 65'd0);
    cmp("rst_in_ready", 65'(b0.in_ready), 65'd1);
    cmp("rst_out_data", {b0.out_fault, 32'd0, b0.out_data}, 65'd0);
    cmp("rst_w64_valid", 65'(b2.out_valid), 65'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;

    dir.push_back('{0, 64'h8899AABB, 1, 0, 1'b1, {1'b0, 64'hFFFFFFAA}});
    dir.push_back('{0, 64'h8899AABB, 1, 0, 1'b0, {1'b0, 64'h000000AA}});
    dir.push_back('{0, 64'h8899AABB, 2, 1, 1'b1, {1'b0, 64'hFFFF8899}});
    dir.push_back('{0, 64'h8899AABB, 0, 2, 1'b1, {1'b0, 64'h8899AABB}});
    dir.push_back('{0, 64'h8899AABB, 1, 1, 1'b1, {1'b1, 64'h0}});
    dir.push_back('{0, 64'h8899AABB, 2, 2, 1'b0, {1'b1, 64'h0}});
    dir.push_back('{0, 64'h8899AABB, 0, 3, 1'b0, {1'b1, 64'h0}});
    dir.push_back('{0, 64'h8899AABB, 3, 0, 1'b0, {1'b0, 64'h00000088}});
    dir.push_back('{1, 64'h8899AABB, 0, 0, 1'b1, {1'b0, 64'hFFFFFF88}});
    dir.push_back('{1, 64'h8899AABB, 2, 1, 1'b0, {1'b0, 64'h0000AABB}});
    dir.push_back('{2, 64'h80000000_7FFFFFFF, 4, 2, 1'b1, {1'b0, 64'hFFFFFFFF_80000000}});
    dir.push_back('{2, 64'h80000000_7FFFFFFF, 0, 2, 1'b1, {1'b0, 64'h00000000_7FFFFFFF}});
    dir.push_back('{2, 64'h80000000_7FFFFFFF, 0, 3, 1'b1, {1'b0, 64'h80000000_7FFFFFFF}});
    dir.push_back('{2, 64'h80000000_7FFFFFFF, 4, 3, 1'b0, {1'b1, 64'h0}});

    for (int d = 0; d < 3; d++) set_ordy(d, 1'b1);
    foreach (dir[i]) begin
      put(dir[i].d, dir[i].w, dir[i].ofs, dir[i].sz, dir[i].sg, dir[i].e);
      cmp($sformatf("latency_%0d", i), 65'(ovalid(dir[i].d)), 65'd1);
    end
    for (int d = 0; d < 3; d++) drain(d);

    // Back-pressure: A and B fill both slots, C waits until A leaves.
    set_ordy(0, 1'b0);
    put(0, 64'h11223344, 0, 0, 1'b0, {1'b0, 64'h44});
    put(0, 64'h11223344, 1, 0, 1'b0, {1'b0, 64'h33});
    cmp("bp_ready_low", 65'(b0.in_ready), 65'd0);
    drive(0, 1'b1, 64'h11223344, 2, 1, 1'b0);
    @(posedge clk); #1;
    cmp("bp_ready_held", 65'(b0.in_ready), 65'd0);
    set_ordy(0, 1'b1);
    @(posedge clk); #1;
    cmp("bp_ready_back", 65'(b0.in_ready), 65'd1);
    @(negedge clk);
    if (b0.in_ready) push(0, {1'b0, 64'h1122});
    @(posedge clk); #1;
    drive(0, 1'b0, 64'd0, 0, 0, 1'b0);
    drain(0);

    for (int d = 0; d < 3; d++) begin
      stim_done = 1'b0;
      fork
        begin rand_run(d, 150); stim_done = 1'b1; end
        begin
          while (!stim_done) begin
            @(posedge clk); #1;
            set_ordy(d, $urandom_range(0, 2) != 0);
          end
        end
      join
      set_ordy(d, 1'b1);
      drain(d);
    end

    // Asynchronous reset with both slots full.
    set_ordy(0, 1'b0);
    put(0, 64'hCAFEF00D, 0, 2, 1'b0, {1'b0, 64'hCAFEF00D});
    put(0, 64'hCAFEF00D, 2, 1, 1'b1, {1'b0, 64'hFFFFCAFE});
    #2 rstn = 1'b0;
    #1;
    cmp("arst_out_valid", 65'(b0.out_valid), 65'd0);
    cmp("arst_in_ready", 65'(b0.in_ready), 65'd1);
    cmp("arst_out_data", {b0.out_fault, 32'd0, b0.out_data}, 65'd0);
    q0.delete();
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;
    set_ordy(0, 1'b1);
    put(0, 64'h0000807F, 1, 0, 1'b1, {1'b0, 64'hFFFFFF80});
    drain(0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/load_extend_unit.md
# load_extend_unit

Parametrised load-data extraction and extension stage for the pipelined datapath. It sits between the data-memory read port and the MEM/WB boundary. For each load it selects the addressed byte, halfword, word or doubleword lane from the memory word, then zero- or sign-extends it to full datapath width. It flags misaligned or illegal accesses. A valid/ready handshake with a two-entry skid buffer gives full throughput under back-pressure.

## Interface

Parameters:
- DATA_W, 32: datapath and memory word width. Legal values are 32 or 64.
- BIG_ENDIAN, 0: 0 means byte offset 0 is bits [7:0]; 1 means byte offset 0 is the most significant byte.
- OFS_W, log2(DATA_W/8): byte-offset width. Derived; do not override.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- in_valid  in  1  a load request is present.
- in_ready  out  1  the unit can accept a request this cycle.
- in_data  in  DATA_W  raw memory read word.
- in_addr_lo  in  OFS_W  byte offset of the access within the word.
- in_size  in  2  access size: 0 byte, 1 half, 2 word, 3 dword (dword is legal only when DATA_W=64).
- in_sign  in  1  1 selects sign extension; 0 selects zero extension.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_data  out  DATA_W  extended load result.
- out_fault  out  1  this result is an alignment or size fault.

## Operation

- An input transfer occurs when in_valid and in_ready are both 1. An output transfer occurs when out_valid and out_ready are both 1.
- Field extraction, with B = access bytes (1, 2, 4 or 8) and NB = DATA_W/8:
  - Little-endian: field = in_data >> (8*in_addr_lo).
  - Big-endian: field = in_data >> (8*(NB - in_addr_lo - B)).
  - Keep the low 8*B bits of the shifted value.
- Extension:
  - in_sign=1: bit 8*B-1 of the field is replicated into all upper bits.
  - in_sign=0: the upper bits are 0.
  - Word access with DATA_W=32 is a pass-through.
- Fault conditions:
  - half with in_addr_lo[0]≠0;
  - word with in_addr_lo[1:0]≠0;
  - dword with in_addr_lo≠0;
  - in_size=3 when DATA_W=32.
- On a fault, out_fault=1 and out_data=0. The fault is still a normal transfer with no stall, and it does not affect any other entry.
- Storage is an output register (OR) plus one skid register (SK). Each holds data, fault and a valid bit. Results are computed combinationally at input and stored already extended.
- Per-edge transitions, evaluated in priority order:
  1. If OR is empty or OR fires and SK is valid: SK moves to OR, SK is cleared, and any accepted input goes to SK.
  2. If OR is empty or OR fires and SK is empty: an accepted input goes to OR.
  3. If OR is held (valid, not firing) and an input is accepted: the input goes to SK.
- Simultaneous accept and fire with SK empty writes the new result straight into OR, so throughput is one per cycle.
- in_ready = !SK.valid, driven from a register with no combinational path from out_ready.
- Order is strictly FIFO; no entry is ever dropped or duplicated.

## Timing

- Reset (rstn=0, asynchronous): out_valid=0, out_data=0, out_fault=0, in_ready=1, SK cleared. Any in-flight entries are discarded immediately, mid-transfer included. Operation resumes on the first rising edge after rstn=1.
- Latency: a request accepted at edge N is presented at out_valid/out_data after edge N, provided OR was free or firing.
- Capacity is 2 entries. After OR and SK are both full, in_ready is 0 in the following cycle.
- out_data and out_fault stay stable while out_valid=1 and out_ready=0.
- in_ready returns to 1 in the cycle after the edge on which SK drains into OR.
- Inputs are ignored whenever in_valid=0 or in_ready=0.

## Test plan

1. DATA_W=32, little-endian, in_data=0x8899AABB, out_ready=1:
   - byte, offset 1, sign=1 → 0xFFFFFFAA;
   - byte, offset 1, sign=0 → 0x000000AA;
   - half, offset 2, sign=1 → 0xFFFF8899;
   - word, offset 0 → 0x8899AABB.
   Each result appears one cycle after acceptance.
2. Faults: half at offset 1, word at offset 2, size 3 on DATA_W=32 → out_fault=1, out_data=0. The following legal byte load completes normally.
3. Back-pressure: hold out_ready=0 and present requests A, B, C. A and B are accepted, then in_ready=0 and C is held. Raise out_ready: the outputs are A, B, C in order, and in_ready returns to 1 one cycle after A fires.
4. BIG_ENDIAN=1, in_data=0x8899AABB:
   - byte, offset 0, sign=1 → 0xFFFFFF88;
   - half, offset 2, sign=0 → 0x0000AABB.
5. DATA_W=64, in_data=0x80000000_7FFFFFFF:
   - word, offset 4, sign=1 → 0xFFFFFFFF_80000000;
   - word, offset 0, sign=1 → 0x00000000_7FFFFFFF;
   - dword, offset 0 → the unchanged word.
6. Reset mid-operation: with both entries full, pull rstn low between clock edges. out_valid=0 and in_ready=1 follow immediately with no edge. After release, the first new request is the first output.
